// File: rtl/v_pkg.sv
// Shared types for the v list engine and its ingress scheduler (v_sched).
package v_pkg;

  localparam int unsigned ID_W    = 8;
  localparam int unsigned CMD_W   = 2;
  localparam int unsigned KEY_W   = 16;
  localparam int unsigned SIZE_W  = 16;
  localparam int unsigned LEVEL_W = 4;

  typedef logic [ID_W-1:0]    id_t;
  typedef logic [CMD_W-1:0]   cmd_t;
  typedef logic [KEY_W-1:0]   key_t;
  typedef logic [SIZE_W-1:0]  size_t;
  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    INIT    = 2'd1,
    RUN     = 2'd2
  } sched_state_t;

  localparam int unsigned SCHED_REQ_N    = 4;
  localparam int unsigned SCHED_HAZARD_N = 4;

  typedef struct packed {
    id_t   prod_id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } upd_t;

  typedef struct packed {
    id_t    prod_id;
    level_t level;
  } lut_t;

endpackage

// File: rtl/v_sched_if.sv
// Requester-side and v-side buses of the ingress scheduler.
interface v_sched_if import v_pkg::*; #(
  parameter int unsigned REQ_N = SCHED_REQ_N
);
  logic                 i_busy;
  logic [REQ_N-1:0]     i_req_upd_vld;
  id_t  [REQ_N-1:0]     i_req_upd_prod_id;
  cmd_t [REQ_N-1:0]     i_req_upd_cmd;
  key_t [REQ_N-1:0]     i_req_upd_key;
  size_t [REQ_N-1:0]    i_req_upd_size;
  logic [REQ_N-1:0]     o_req_upd_rdy;
  logic                 i_req_lut_vld;
  id_t                  i_req_lut_prod_id;
  level_t               i_req_lut_level;
  logic                 o_req_lut_rdy;
  logic                 o_upd_vld_r;
  id_t                  o_upd_prod_id_r;
  cmd_t                 o_upd_cmd_r;
  key_t                 o_upd_key_r;
  size_t                o_upd_size_r;
  logic                 o_lut_vld_r;
  id_t                  o_lut_prod_id_r;
  level_t               o_lut_level_r;
  sched_state_t         o_state_r;

  modport master (
    output i_busy, i_req_upd_vld, i_req_upd_prod_id, i_req_upd_cmd, i_req_upd_key,
           i_req_upd_size, i_req_lut_vld, i_req_lut_prod_id, i_req_lut_level,
    input  o_req_upd_rdy, o_req_lut_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r,
           o_upd_key_r, o_upd_size_r, o_lut_vld_r, o_lut_prod_id_r, o_lut_level_r,
           o_state_r
  );

  modport slave (
    input  i_busy, i_req_upd_vld, i_req_upd_prod_id, i_req_upd_cmd, i_req_upd_key,
           i_req_upd_size, i_req_lut_vld, i_req_lut_prod_id, i_req_lut_level,
    output o_req_upd_rdy, o_req_lut_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r,
           o_upd_key_r, o_upd_size_r, o_lut_vld_r, o_lut_prod_id_r, o_lut_level_r,
           o_state_r
  );
endinterface

// File: rtl/v_sched_rr.sv
// Generic round-robin arbiter: search upward from the pointer, pointer moves past each grant.
module v_sched_rr #(
  parameter int unsigned REQ_N = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_N-1:0]           req,
  output logic [REQ_N-1:0]           gnt,
  output logic [$clog2(REQ_N)-1:0]   gnt_idx
);
  localparam int unsigned IDX_W = $clog2(REQ_N);

  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < REQ_N; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % REQ_N);
      if (!found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

  // Every grant is an accept, so the pointer always advances on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (|gnt) begin
      ptr_q <= IDX_W'((32'(gnt_idx) + 1) % REQ_N);
    end
  end
endmodule

// File: rtl/v_sched.sv
// Ingress scheduler in front of v: RR update arbitration, lookup issue, init gating.
// Optional lookup-vs-update hazard stall built when V_SCHED_HAZARD_EN is defined.
module v_sched import v_pkg::*; #(
  parameter int unsigned REQ_N    = SCHED_REQ_N,
  parameter int unsigned HAZARD_N = SCHED_HAZARD_N
) (
  input logic      clk,
  input logic      rst,
  v_sched_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(REQ_N);

  sched_state_t     state_q, state_d;
  logic             run_c;
  logic [REQ_N-1:0] req_c, gnt_c;
  logic [IDX_W-1:0] gnt_idx_c;
  logic             upd_fire_c, lut_rdy_c, lut_fire_c, hazard_c;
  upd_t             sel_c, upd_q;
  lut_t             lut_q;
  logic             upd_vld_q, lut_vld_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_HI;
    else     state_q <= state_d;
  end

  // Grants are masked during the reset cycle so a held request is never lost to it.
  always_comb begin
    state_d = state_q;
    run_c   = 1'b0;
    case (state_q)
      WAIT_HI: if (bus.i_busy) state_d = INIT;
      INIT:    if (!bus.i_busy) state_d = RUN;
      RUN: begin
        run_c = !rst;
        if (bus.i_busy) state_d = INIT;
      end
      default: state_d = WAIT_HI;
    endcase
  end

  assign req_c = bus.i_req_upd_vld & {REQ_N{run_c}};

  v_sched_rr #(.REQ_N(REQ_N)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_c),
    .gnt     (gnt_c),
    .gnt_idx (gnt_idx_c)
  );

  assign upd_fire_c = |gnt_c;
  assign sel_c = '{prod_id: bus.i_req_upd_prod_id[gnt_idx_c],
                   cmd:     bus.i_req_upd_cmd[gnt_idx_c],
                   key:     bus.i_req_upd_key[gnt_idx_c],
                   size:    bus.i_req_upd_size[gnt_idx_c]};

`ifdef V_SCHED_HAZARD_EN
  logic [HAZARD_N-1:0] sb_vld_q;
  id_t  [HAZARD_N-1:0] sb_id_q;

  // Ages issued updates through the v update pipe; emptied whenever not running.
  always_ff @(posedge clk) begin
    if (rst || state_q != RUN) begin
      sb_vld_q <= '0;
      sb_id_q  <= '0;
    end else begin
      for (int unsigned i = HAZARD_N - 1; i > 0; i--) begin
        sb_vld_q[i] <= sb_vld_q[i-1];
        sb_id_q[i]  <= sb_id_q[i-1];
      end
      sb_vld_q[0] <= upd_fire_c;
      sb_id_q[0]  <= upd_fire_c ? sel_c.prod_id : '0;
    end
  end

  always_comb begin
    hazard_c = upd_fire_c && (sel_c.prod_id == bus.i_req_lut_prod_id);
    for (int unsigned i = 0; i < HAZARD_N; i++) begin
      if (sb_vld_q[i] && sb_id_q[i] == bus.i_req_lut_prod_id) hazard_c = 1'b1;
    end
  end
`else
  logic unused_hazard_n;
  assign unused_hazard_n = ^HAZARD_N;
  assign hazard_c        = 1'b0;
`endif

  assign lut_rdy_c  = run_c && !hazard_c;
  assign lut_fire_c = bus.i_req_lut_vld && lut_rdy_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_vld_q <= 1'b0;
      upd_q     <= '0;
      lut_vld_q <= 1'b0;
      lut_q     <= '0;
    end else begin
      upd_vld_q <= upd_fire_c;
      upd_q     <= upd_fire_c ? sel_c : '0;
      lut_vld_q <= lut_fire_c;
      lut_q     <= lut_fire_c ? lut_t'{prod_id: bus.i_req_lut_prod_id,
                                       level:   bus.i_req_lut_level} : '0;
    end
  end

  assign bus.o_req_upd_rdy   = gnt_c;
  assign bus.o_req_lut_rdy   = lut_rdy_c;
  assign bus.o_upd_vld_r     = upd_vld_q;
  assign bus.o_upd_prod_id_r = upd_q.prod_id;
  assign bus.o_upd_cmd_r     = upd_q.cmd;
  assign bus.o_upd_key_r     = upd_q.key;
  assign bus.o_upd_size_r    = upd_q.size;
  assign bus.o_lut_vld_r     = lut_vld_q;
  assign bus.o_lut_prod_id_r = lut_q.prod_id;
  assign bus.o_lut_level_r   = lut_q.level;
  assign bus.o_state_r       = state_q;
endmodule

// File: tb/tb_v_sched.sv
// Self-checking bench for v_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_v_sched;
  import v_pkg::*;

  localparam int N  = 4;
  localparam int HN = 4;
`ifdef V_SCHED_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  v_sched_if #(.REQ_N(N)) bus ();
  v_sched #(.REQ_N(N), .HAZARD_N(HN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  sched_state_t m_state;
  int           m_ptr;
  int           m_hist[HN];
  logic         m_upd_vld, m_lut_vld;
  id_t          m_upd_id, m_lut_id;
  cmd_t         m_upd_cmd;
  key_t         m_upd_key;
  size_t        m_upd_size;
  level_t       m_lut_level;
  int           e_grant;
  logic [N-1:0] e_rdy;
  logic         e_lut_rdy;

  function automatic void model_reset();
    m_state = WAIT_HI; m_ptr = 0;
    foreach (m_hist[i]) m_hist[i] = -1;
    m_upd_vld = 0; m_upd_id = '0; m_upd_cmd = '0; m_upd_key = '0; m_upd_size = '0;
    m_lut_vld = 0; m_lut_id = '0; m_lut_level = '0;
  endfunction

  function automatic void model_eval();
    bit run, haz;
    run = (m_state == RUN) && !rst;
    e_grant = -1;
    if (run) begin
      for (int k = 0; k < N; k++) begin
        int r;
        r = (m_ptr + k) % N;
        if (e_grant < 0 && bus.i_req_upd_vld[r]) e_grant = r;
      end
    end
    e_rdy = '0;
    if (e_grant >= 0) e_rdy[e_grant] = 1'b1;
    haz = 0;
    if (HAZ_EN) begin
      foreach (m_hist[i]) if (m_hist[i] == int'(bus.i_req_lut_prod_id)) haz = 1;
      if (e_grant >= 0 && bus.i_req_upd_prod_id[e_grant] == bus.i_req_lut_prod_id) haz = 1;
    end
    e_lut_rdy = run && !haz;
  endfunction

  function automatic void model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    m_upd_vld = (e_grant >= 0);
    if (m_upd_vld) begin
      m_upd_id   = bus.i_req_upd_prod_id[e_grant];
      m_upd_cmd  = bus.i_req_upd_cmd[e_grant];
      m_upd_key  = bus.i_req_upd_key[e_grant];
      m_upd_size = bus.i_req_upd_size[e_grant];
      m_ptr      = (e_grant + 1) % N;
    end
    m_lut_vld = bus.i_req_lut_vld && e_lut_rdy;
    if (m_lut_vld) begin
      m_lut_id    = bus.i_req_lut_prod_id;
      m_lut_level = bus.i_req_lut_level;
    end
    if (m_state == RUN) begin
      for (int i = HN - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_upd_vld ? int'(m_upd_id) : -1;
    end else begin
      foreach (m_hist[i]) m_hist[i] = -1;
    end
    case (m_state)
      WAIT_HI: if (bus.i_busy)  m_state = INIT;
      INIT:    if (!bus.i_busy) m_state = RUN;
      default: if (bus.i_busy)  m_state = INIT;
    endcase
  endfunction

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_reqs();
    bus.i_req_upd_vld = '0;
    bus.i_req_lut_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin settle(); advance(); end
  endtask

  task automatic bring_up();
    rst = 1'b1; settle(); advance();
    rst = 1'b0; bus.i_busy = 1'b1; idle(2);
    bus.i_busy = 1'b0; settle(); advance();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_req_upd_vld = '1; bus.i_req_lut_vld = 1'b1;
    settle(); advance(); settle();
    n_cmp++; if (bus.o_state_r !== WAIT_HI) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", bus.o_state_r, WAIT_HI); end
    n_cmp++; if (bus.o_upd_vld_r !== 1'b0 || bus.o_lut_vld_r !== 1'b0) begin n_err++; $display("FAIL reset_vld got=%b%b exp=00", bus.o_upd_vld_r, bus.o_lut_vld_r); end
    n_cmp++; if ({bus.o_upd_prod_id_r, bus.o_upd_cmd_r, bus.o_upd_key_r, bus.o_upd_size_r, bus.o_lut_prod_id_r, bus.o_lut_level_r} !== '0) begin n_err++; $display("FAIL reset_payload got nonzero exp=0"); end
    n_cmp++; if (bus.o_req_upd_rdy !== 4'b0000 || bus.o_req_lut_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got=%b/%b exp=0000/0", bus.o_req_upd_rdy, bus.o_req_lut_rdy); end
    advance();
    rst = 1'b0; clear_reqs();
  endtask

  task automatic test_init_gating();
    bus.i_req_upd_vld = 4'b0001;
    bus.i_req_upd_prod_id[0] = 8'h11;
    for (int c = 0; c < 16; c++) begin
      logic [N-1:0] exp_rdy;
      bus.i_busy = (c >= 3 && c < 13);
      exp_rdy = (c == 14) ? 4'b0001 : 4'b0000;
      settle();
      n_cmp++; if (bus.o_req_upd_rdy !== exp_rdy) begin n_err++; $display("FAIL init_rdy c=%0d got=%b exp=%b", c, bus.o_req_upd_rdy, exp_rdy); end
      if (c == 15) begin
        n_cmp++; if (bus.o_upd_vld_r !== 1'b1 || bus.o_upd_prod_id_r !== 8'h11) begin n_err++; $display("FAIL init_issue got vld=%b id=%h exp vld=1 id=11", bus.o_upd_vld_r, bus.o_upd_prod_id_r); end
      end
      advance();
      if (c == 14) bus.i_req_upd_vld = '0;
    end
    clear_reqs();
  endtask

  task automatic test_round_robin();
    bring_up();
    for (int r = 0; r < N; r++) bus.i_req_upd_prod_id[r] = id_t'(r + 1);
    bus.i_req_upd_vld = '1;
    for (int k = 0; k < 12; k++) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = '0; exp_rdy[k % N] = 1'b1;
      settle();
      n_cmp++; if (bus.o_req_upd_rdy !== exp_rdy) begin n_err++; $display("FAIL rr_rdy k=%0d got=%b exp=%b", k, bus.o_req_upd_rdy, exp_rdy); end
      if (k > 0) begin
        n_cmp++; if (bus.o_upd_vld_r !== 1'b1 || bus.o_upd_prod_id_r !== id_t'(((k - 1) % N) + 1)) begin n_err++; $display("FAIL rr_issue k=%0d got vld=%b id=%0d exp id=%0d", k, bus.o_upd_vld_r, bus.o_upd_prod_id_r, ((k - 1) % N) + 1); end
      end
      advance();
    end
    clear_reqs();
  endtask

  task automatic test_sparse_rr();
    int seq[4] = '{3, 1, 3, 1};
    idle(1);
    bus.i_req_upd_vld = 4'b0010;
    settle();
    n_cmp++; if (bus.o_req_upd_rdy !== 4'b0010) begin n_err++; $display("FAIL sparse_prime got=%b exp=0010", bus.o_req_upd_rdy); end
    advance();
    for (int r = 0; r < N; r++) bus.i_req_upd_prod_id[r] = id_t'(8'h20 + r);
    bus.i_req_upd_vld = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = '0;
      if (k < 4) exp_rdy[seq[k]] = 1'b1;
      if (k == 4) bus.i_req_upd_vld = '0;
      settle();
      n_cmp++; if (bus.o_req_upd_rdy !== exp_rdy) begin n_err++; $display("FAIL sparse_rdy k=%0d got=%b exp=%b", k, bus.o_req_upd_rdy, exp_rdy); end
      if (k > 0) begin
        n_cmp++; if (bus.o_upd_prod_id_r !== id_t'(8'h20 + seq[k-1])) begin n_err++; $display("FAIL sparse_issue k=%0d got=%h exp=%h", k, bus.o_upd_prod_id_r, 8'h20 + seq[k-1]); end
      end
      advance();
    end
    clear_reqs();
  endtask

  task automatic hazard_case(input id_t lut_id, input string tag);
    bit accepted = 0;
    idle(6);
    bus.i_req_upd_vld = 4'b0001; bus.i_req_upd_prod_id[0] = 8'd5;
    bus.i_req_lut_vld = 1'b1; bus.i_req_lut_prod_id = lut_id; bus.i_req_lut_level = 4'd3;
    for (int k = 0; k < 10 && !accepted; k++) begin
      logic exp_rdy;
      exp_rdy = (HAZ_EN && lut_id == 8'd5) ? (k >= HN + 1) : 1'b1;
      settle();
      n_cmp++; if (bus.o_req_lut_rdy !== exp_rdy) begin n_err++; $display("FAIL %s_lut_rdy k=%0d got=%b exp=%b", tag, k, bus.o_req_lut_rdy, exp_rdy); end
      accepted = exp_rdy;
      advance();
      bus.i_req_upd_vld = '0;
    end
    bus.i_req_lut_vld = 1'b0;
    settle();
    n_cmp++; if (bus.o_lut_vld_r !== 1'b1 || bus.o_lut_prod_id_r !== lut_id || bus.o_lut_level_r !== 4'd3) begin n_err++; $display("FAIL %s_lut_issue got vld=%b id=%0d lvl=%0d exp vld=1 id=%0d lvl=3", tag, bus.o_lut_vld_r, bus.o_lut_prod_id_r, bus.o_lut_level_r, lut_id); end
    advance();
  endtask

  task automatic test_hazard();
    hazard_case(8'd5, "haz_same");
    hazard_case(8'd6, "haz_other");
  endtask

  task automatic test_mid_reset();
    bring_up();
    for (int r = 0; r < N; r++) bus.i_req_upd_prod_id[r] = id_t'(r + 1);
    bus.i_req_upd_vld = '1;
    bus.i_req_lut_vld = 1'b1; bus.i_req_lut_prod_id = 8'd9;
    idle(5);
    rst = 1'b1;
    settle();
    n_cmp++; if (bus.o_req_upd_rdy !== 4'b0000 || bus.o_req_lut_rdy !== 1'b0) begin n_err++; $display("FAIL mrst_rdy_in_rst got=%b/%b exp=0000/0", bus.o_req_upd_rdy, bus.o_req_lut_rdy); end
    advance();
    rst = 1'b0;
    settle();
    n_cmp++; if (bus.o_upd_vld_r !== 1'b0 || bus.o_lut_vld_r !== 1'b0 || bus.o_state_r !== WAIT_HI) begin n_err++; $display("FAIL mrst_out got vld=%b%b st=%0d exp vld=00 st=0", bus.o_upd_vld_r, bus.o_lut_vld_r, bus.o_state_r); end
    advance();
    for (int c = 0; c < 6; c++) begin
      bus.i_busy = (c == 3 || c == 4);
      settle();
      n_cmp++; if (bus.o_req_upd_rdy !== 4'b0000 || bus.o_req_lut_rdy !== 1'b0) begin n_err++; $display("FAIL mrst_hold c=%0d got=%b/%b exp=0000/0", c, bus.o_req_upd_rdy, bus.o_req_lut_rdy); end
      advance();
    end
    settle();
    n_cmp++; if (bus.o_req_upd_rdy !== 4'b0001 || bus.o_req_lut_rdy !== 1'b1) begin n_err++; $display("FAIL mrst_resume got=%b/%b exp=0001/1", bus.o_req_upd_rdy, bus.o_req_lut_rdy); end
    advance();
    settle();
    n_cmp++; if (bus.o_upd_vld_r !== 1'b1 || bus.o_upd_prod_id_r !== 8'd1) begin n_err++; $display("FAIL mrst_pending got vld=%b id=%0d exp vld=1 id=1", bus.o_upd_vld_r, bus.o_upd_prod_id_r); end
    advance();
    clear_reqs();
  endtask

  task automatic test_random();
    int busy_left = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (busy_left > 0) busy_left--;
      else if ($urandom_range(0, 59) == 0) busy_left = $urandom_range(1, 4);
      bus.i_busy = (busy_left > 0);
      settle();
      n_cmp++; if (bus.o_req_upd_rdy !== e_rdy) begin n_err++; $display("FAIL rnd_upd_rdy cyc=%0d got=%b exp=%b", cyc, bus.o_req_upd_rdy, e_rdy); end
      n_cmp++; if (bus.o_req_lut_rdy !== e_lut_rdy) begin n_err++; $display("FAIL rnd_lut_rdy cyc=%0d got=%b exp=%b", cyc, bus.o_req_lut_rdy, e_lut_rdy); end
      n_cmp++; if (bus.o_state_r !== m_state) begin n_err++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", cyc, bus.o_state_r, m_state); end
      n_cmp++;
      if (bus.o_upd_vld_r !== m_upd_vld || (m_upd_vld && {bus.o_upd_prod_id_r, bus.o_upd_cmd_r, bus.o_upd_key_r, bus.o_upd_size_r} !== {m_upd_id, m_upd_cmd, m_upd_key, m_upd_size})) begin
        n_err++; $display("FAIL rnd_upd_out cyc=%0d got vld=%b id=%0d key=%h exp vld=%b id=%0d key=%h", cyc, bus.o_upd_vld_r, bus.o_upd_prod_id_r, bus.o_upd_key_r, m_upd_vld, m_upd_id, m_upd_key);
      end
      n_cmp++;
      if (bus.o_lut_vld_r !== m_lut_vld || (m_lut_vld && {bus.o_lut_prod_id_r, bus.o_lut_level_r} !== {m_lut_id, m_lut_level})) begin
        n_err++; $display("FAIL rnd_lut_out cyc=%0d got vld=%b id=%0d exp vld=%b id=%0d", cyc, bus.o_lut_vld_r, bus.o_lut_prod_id_r, m_lut_vld, m_lut_id);
      end
      advance();
      // Requesters hold a request until it is accepted, then may raise a new one.
      for (int r = 0; r < N; r++) begin
        if (bus.i_req_upd_vld[r] && e_grant == r) bus.i_req_upd_vld[r] = 1'b0;
        if (!bus.i_req_upd_vld[r] && $urandom_range(0, 2) != 0) begin
          bus.i_req_upd_vld[r]     = 1'b1;
          bus.i_req_upd_prod_id[r] = id_t'($urandom_range(0, 7));
          bus.i_req_upd_cmd[r]     = cmd_t'($urandom);
          bus.i_req_upd_key[r]     = key_t'($urandom);
          bus.i_req_upd_size[r]    = size_t'($urandom);
        end
      end
      if (bus.i_req_lut_vld && e_lut_rdy && !rst) bus.i_req_lut_vld = 1'b0;
      if (!bus.i_req_lut_vld && $urandom_range(0, 1) != 0) begin
        bus.i_req_lut_vld     = 1'b1;
        bus.i_req_lut_prod_id = id_t'($urandom_range(0, 7));
        bus.i_req_lut_level   = level_t'($urandom);
      end
    end
    rst = 1'b0; bus.i_busy = 1'b0;
    clear_reqs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_busy = 1'b0;
    bus.i_req_upd_vld = '0; bus.i_req_upd_prod_id = '0; bus.i_req_upd_cmd = '0;
    bus.i_req_upd_key = '0; bus.i_req_upd_size = '0;
    bus.i_req_lut_vld = 1'b0; bus.i_req_lut_prod_id = '0; bus.i_req_lut_level = '0;
    model_reset();
    test_reset();
    test_init_gating();
    test_round_robin();
    test_sparse_rr();
    test_hazard();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
